// File: rtl/msrh_rob.sv
// msrh_rob: in-order commit buffer with per-slot completion tracking.
// Optional macro MSRH_ROB_DONE_CHECK_EN enables the sticky o_err checker.
module msrh_rob #(
    parameter int DISP_SIZE    = 5,
    parameter int CMT_BLK_SIZE = 64,
    parameter int RNID_W       = 8,
    parameter int VADDR_W      = 39,
    parameter int DONE_PORTS   = 2,
    localparam int CMT_BLK_W   = $clog2(CMT_BLK_SIZE)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_disp_valid,
    output logic                            o_disp_ready,
    input  logic [VADDR_W-2:0]              i_disp_pc,
    input  logic [DISP_SIZE-1:0]            i_disp_grp_id,
    input  logic [DISP_SIZE-1:0]            i_disp_old_rd_valid,
    input  logic [DISP_SIZE*RNID_W-1:0]     i_disp_old_rd_rnid,
    output logic [CMT_BLK_W-1:0]            o_disp_cmt_id,
    input  logic [DONE_PORTS-1:0]           i_done_valid,
    input  logic [DONE_PORTS*CMT_BLK_W-1:0] i_done_cmt_id,
    input  logic [DONE_PORTS*DISP_SIZE-1:0] i_done_grp_id,
    input  logic [DONE_PORTS-1:0]           i_done_exc_vld,
    output logic                            o_cmt_valid,
    output logic [CMT_BLK_W-1:0]            o_cmt_id,
    output logic [VADDR_W-2:0]              o_cmt_pc,
    output logic [DISP_SIZE-1:0]            o_cmt_grp_id,
    output logic                            o_cmt_exc,
    output logic [DISP_SIZE-1:0]            o_rel_valid,
    output logic [DISP_SIZE*RNID_W-1:0]     o_rel_rnid,
    output logic                            o_flush,
    output logic                            o_err
);

    localparam logic [CMT_BLK_W:0] FULL_CNT = (CMT_BLK_W+1)'(CMT_BLK_SIZE);

    logic [CMT_BLK_SIZE-1:0]        ent_valid;
    logic [CMT_BLK_SIZE-1:0]        ent_exc;
    logic [VADDR_W-2:0]             ent_pc       [CMT_BLK_SIZE];
    logic [DISP_SIZE-1:0]           ent_grp      [CMT_BLK_SIZE];
    logic [DISP_SIZE-1:0]           ent_old_vld  [CMT_BLK_SIZE];
    logic [DISP_SIZE*RNID_W-1:0]    ent_old_rnid [CMT_BLK_SIZE];
    logic [DISP_SIZE-1:0]           ent_done     [CMT_BLK_SIZE];

    logic [CMT_BLK_W-1:0] head;
    logic [CMT_BLK_W-1:0] tail;
    logic [CMT_BLK_W:0]   count;
    logic                 flush_pending;

    logic [CMT_BLK_W-1:0] d_id  [DONE_PORTS];
    logic [DISP_SIZE-1:0] d_grp [DONE_PORTS];
    logic [DISP_SIZE-1:0] done_set [CMT_BLK_SIZE];
    logic [CMT_BLK_SIZE-1:0] exc_set;

    logic disp_fire;
    logic cmt_valid;

    assign o_disp_ready  = (count != FULL_CNT) && !flush_pending;
    assign disp_fire     = i_disp_valid && o_disp_ready;
    assign o_disp_cmt_id = tail;
    assign o_flush       = flush_pending;

    // Younger groups must not retire while an exception flush is pending
    assign cmt_valid = !flush_pending && ent_valid[head] &&
                       (ent_done[head] == ent_grp[head]);

    // Drive commit and release outputs, zeroed when nothing retires
    always_comb begin
        o_cmt_valid  = cmt_valid;
        o_cmt_id     = '0;
        o_cmt_pc     = '0;
        o_cmt_grp_id = '0;
        o_cmt_exc    = 1'b0;
        o_rel_valid  = '0;
        o_rel_rnid   = '0;
        if (cmt_valid) begin
            o_cmt_id     = head;
            o_cmt_pc     = ent_pc[head];
            o_cmt_grp_id = ent_grp[head];
            o_cmt_exc    = ent_exc[head];
            o_rel_valid  = ent_old_vld[head] & ent_grp[head];
            o_rel_rnid   = ent_old_rnid[head];
        end
    end

    // Unpack done ports and merge reports aimed at the same entry
    always_comb begin
        for (int e = 0; e < CMT_BLK_SIZE; e++) begin
            done_set[e] = '0;
            exc_set[e]  = 1'b0;
        end
        for (int p = 0; p < DONE_PORTS; p++) begin
            d_id[p]  = i_done_cmt_id[p*CMT_BLK_W +: CMT_BLK_W];
            d_grp[p] = i_done_grp_id[p*DISP_SIZE +: DISP_SIZE];
            if (i_done_valid[p]) begin
                done_set[d_id[p]] = done_set[d_id[p]] | d_grp[p];
                exc_set[d_id[p]]  = exc_set[d_id[p]] | i_done_exc_vld[p];
            end
        end
    end

    // Entry state, pointers, occupancy and flush sequencing
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ent_valid     <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
        end else if (flush_pending) begin
            ent_valid     <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
        end else begin
            for (int e = 0; e < CMT_BLK_SIZE; e++) begin
                if (ent_valid[e]) begin
                    ent_done[e] <= ent_done[e] | done_set[e];
                    ent_exc[e]  <= ent_exc[e] | exc_set[e];
                end
            end
            if (cmt_valid) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
                if (ent_exc[head]) flush_pending <= 1'b1;
            end
            if (disp_fire) begin
                ent_valid[tail]    <= 1'b1;
                ent_pc[tail]       <= i_disp_pc;
                ent_grp[tail]      <= i_disp_grp_id;
                ent_old_vld[tail]  <= i_disp_old_rd_valid;
                ent_old_rnid[tail] <= i_disp_old_rd_rnid;
                ent_done[tail]     <= '0;
                ent_exc[tail]      <= 1'b0;
                tail               <= tail + 1'b1;
            end
            case ({disp_fire, cmt_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MSRH_ROB_DONE_CHECK_EN
    logic err_q;
    logic err_hit;

    // Flag reports to empty entries, repeated slots or foreign slots
    always_comb begin
        err_hit = 1'b0;
        for (int p = 0; p < DONE_PORTS; p++) begin
            if (i_done_valid[p] && !flush_pending) begin
                if (!ent_valid[d_id[p]]) begin
                    err_hit = 1'b1;
                end else if (|(ent_done[d_id[p]] & d_grp[p]) ||
                             |(d_grp[p] & ~ent_grp[d_id[p]])) begin
                    err_hit = 1'b1;
                end
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_reset) err_q <= 1'b0;
        else if (err_hit) err_q <= 1'b1;
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_msrh_rob.sv
// tb_msrh_rob: directed stimulus against a queue-based reference model.
// Outputs are compared on every falling edge plus literal spot checks.
module tb_msrh_rob;

    localparam int DS = 5;
    localparam int NE = 64;
    localparam int W  = 6;
    localparam int RW = 8;
    localparam int VW = 39;
    localparam int DP = 2;

`ifdef MSRH_ROB_DONE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_valid;
    logic              disp_ready;
    logic [VW-2:0]     disp_pc;
    logic [DS-1:0]     disp_grp;
    logic [DS-1:0]     disp_oldv;
    logic [DS*RW-1:0]  disp_rnid;
    logic [W-1:0]      disp_cmt_id;
    logic [DP-1:0]     done_valid;
    logic [DP*W-1:0]   done_id;
    logic [DP*DS-1:0]  done_grp;
    logic [DP-1:0]     done_exc;
    logic              cmt_valid;
    logic [W-1:0]      cmt_id;
    logic [VW-2:0]     cmt_pc;
    logic [DS-1:0]     cmt_grp;
    logic              cmt_exc;
    logic [DS-1:0]     rel_valid;
    logic [DS*RW-1:0]  rel_rnid;
    logic              flush;
    logic              err;

    msrh_rob dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_disp_valid        (disp_valid),
        .o_disp_ready        (disp_ready),
        .i_disp_pc           (disp_pc),
        .i_disp_grp_id       (disp_grp),
        .i_disp_old_rd_valid (disp_oldv),
        .i_disp_old_rd_rnid  (disp_rnid),
        .o_disp_cmt_id       (disp_cmt_id),
        .i_done_valid        (done_valid),
        .i_done_cmt_id       (done_id),
        .i_done_grp_id       (done_grp),
        .i_done_exc_vld      (done_exc),
        .o_cmt_valid         (cmt_valid),
        .o_cmt_id            (cmt_id),
        .o_cmt_pc            (cmt_pc),
        .o_cmt_grp_id        (cmt_grp),
        .o_cmt_exc           (cmt_exc),
        .o_rel_valid         (rel_valid),
        .o_rel_rnid          (rel_rnid),
        .o_flush             (flush),
        .o_err               (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-order queue of live groups
    typedef struct {
        int             id;
        logic [VW-2:0]  pc;
        logic [DS-1:0]  grp;
        logic [DS-1:0]  oldv;
        logic [DS*RW-1:0] rnid;
        logic [DS-1:0]  done;
        logic           exc;
    } grp_t;

    grp_t q[$];
    int   m_tail = 0;
    bit   m_fp   = 1'b0;
    bit   m_err  = 1'b0;

    function automatic int find(input int id);
        foreach (q[i]) if (q[i].id == id) return i;
        return -1;
    endfunction

    function automatic bit m_commit();
        if (m_fp || q.size() == 0) return 1'b0;
        return q[0].done == q[0].grp;
    endfunction

    always @(posedge clk) begin
        bit cv, hexc, rdy;
        int k;
        logic [DS-1:0] g;
        if (rst) begin
            q.delete();
            m_tail = 0;
            m_fp   = 1'b0;
            m_err  = 1'b0;
        end else if (m_fp) begin
            q.delete();
            m_tail = 0;
            m_fp   = 1'b0;
        end else begin
            cv   = m_commit();
            hexc = (q.size() > 0) ? q[0].exc : 1'b0;
            rdy  = q.size() != NE;
`ifdef MSRH_ROB_DONE_CHECK_EN
            for (int p = 0; p < DP; p++) begin
                if (done_valid[p]) begin
                    k = find(int'(done_id[p*W +: W]));
                    g = done_grp[p*DS +: DS];
                    if (k < 0) m_err = 1'b1;
                    else if ((q[k].done & g) != 0 || (g & ~q[k].grp) != 0)
                        m_err = 1'b1;
                end
            end
`endif
            for (int p = 0; p < DP; p++) begin
                if (done_valid[p]) begin
                    k = find(int'(done_id[p*W +: W]));
                    if (k >= 0) begin
                        q[k].done = q[k].done | done_grp[p*DS +: DS];
                        q[k].exc  = q[k].exc | done_exc[p];
                    end
                end
            end
            if (cv) begin
                if (hexc) m_fp = 1'b1;
                void'(q.pop_front());
            end
            if (disp_valid && rdy) begin
                q.push_back('{m_tail, disp_pc, disp_grp, disp_oldv,
                              disp_rnid, '0, 1'b0});
                m_tail = (m_tail + 1) % NE;
            end
        end
    end

    // Compare every output against the model each cycle
    always @(negedge clk) begin
        bit cv;
        if (chk_en) begin
            cv = m_commit();
            chk("disp_ready", disp_ready, (q.size() != NE) && !m_fp);
            chk("disp_cmt_id", disp_cmt_id, m_tail);
            chk("cmt_valid", cmt_valid, cv);
            chk("cmt_id", cmt_id, cv ? q[0].id : 0);
            chk("cmt_pc", cmt_pc, cv ? q[0].pc : '0);
            chk("cmt_grp", cmt_grp, cv ? q[0].grp : '0);
            chk("cmt_exc", cmt_exc, cv ? q[0].exc : 1'b0);
            chk("rel_valid", rel_valid, cv ? (q[0].oldv & q[0].grp) : '0);
            chk("rel_rnid", rel_rnid, cv ? q[0].rnid : '0);
            chk("flush", flush, m_fp);
            chk("err", err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [VW-2:0] pc, input logic [DS-1:0] g,
                            input logic [DS-1:0] ov, input logic [DS*RW-1:0] rn);
        disp_valid = 1'b1;
        disp_pc    = pc;
        disp_grp   = g;
        disp_oldv  = ov;
        disp_rnid  = rn;
    endtask

    task automatic set_done(input int p, input int id, input logic [DS-1:0] g,
                            input logic e);
        logic [W-1:0] idv;
        idv = W'(id);
        done_valid[p]        = 1'b1;
        done_id[p*W +: W]    = idv;
        done_grp[p*DS +: DS] = g;
        done_exc[p]          = e;
    endtask

    task automatic clr_in();
        disp_valid = 1'b0;
        done_valid = '0;
        done_exc   = '0;
    endtask

    initial begin
        rst = 1'b1;
        disp_pc = '0; disp_grp = '0; disp_oldv = '0; disp_rnid = '0;
        done_id = '0; done_grp = '0;
        clr_in();
        tick();
        chk_en = 1'b1;
        tick();
        chk("lit_rst_ready", disp_ready, 1);
        chk("lit_rst_cmt", cmt_valid, 0);
        chk("lit_rst_flush", flush, 0);
        chk("lit_rst_id", disp_cmt_id, 0);
        chk("lit_rst_err", err, 0);
        rst = 1'b0;

        // two-slot group completed by both ports in one cycle
        set_disp(38'h100, 5'b00011, 5'b00000, '0);
        tick();
        clr_in();
        chk("lit_alloc_id", disp_cmt_id, 1);
        tick();
        tick();
        set_done(0, 0, 5'b00001, 1'b0);
        set_done(1, 0, 5'b00010, 1'b0);
        tick();
        clr_in();
        chk("lit_c0_valid", cmt_valid, 1);
        chk("lit_c0_id", cmt_id, 0);
        chk("lit_c0_grp", cmt_grp, 5'b00011);
        chk("lit_c0_pc", cmt_pc, 38'h100);
        tick();
        chk("lit_c0_gone", cmt_valid, 0);

        // release of old rename id
        set_disp(38'h204, 5'b00001, 5'b00001, 40'h2A);
        tick();
        clr_in();
        set_done(0, 1, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_rel_valid", rel_valid, 5'b00001);
        chk("lit_rel_rnid", rel_rnid[RW-1:0], 8'h2A);
        tick();

        // out-of-order completion, in-order commit
        set_disp(38'h300, 5'b00001, 5'b0, '0);
        tick();
        set_disp(38'h304, 5'b00011, 5'b00010, 40'h1100);
        tick();
        clr_in();
        set_done(0, 3, 5'b00001, 1'b0);
        set_done(1, 3, 5'b00010, 1'b0);
        tick();
        clr_in();
        chk("lit_ooo_wait", cmt_valid, 0);
        tick();
        set_done(0, 2, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_ooo_c2", cmt_id, 2);
        tick();
        chk("lit_ooo_c3v", cmt_valid, 1);
        chk("lit_ooo_c3", cmt_id, 3);
        tick();
        chk("lit_ooo_end", cmt_valid, 0);

        // fill to capacity from id 0, one extra dispatch is dropped
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NE + 1; i++) begin
            set_disp(38'(i), 5'b00001, 5'b00001, 40'(i));
            tick();
        end
        clr_in();
        chk("lit_full_ready", disp_ready, 0);
        chk("lit_full_wrap", disp_cmt_id, 0);
        set_done(0, 0, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_full_cmt", cmt_valid, 1);
        chk("lit_full_still", disp_ready, 0);
        tick();
        chk("lit_full_free", disp_ready, 1);
        set_disp(38'h55, 5'b00001, 5'b0, '0);
        tick();
        clr_in();
        chk("lit_full_again", disp_ready, 0);
        chk("lit_full_tail", disp_cmt_id, 1);

        // reset mid-operation discards everything
        set_done(0, 1, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_mid_cmt", cmt_valid, 1);
        rst = 1'b1;
        set_done(0, 2, 5'b00001, 1'b0);
        tick();
        clr_in();
        rst = 1'b0;
        chk("lit_mid_none", cmt_valid, 0);
        chk("lit_mid_ready", disp_ready, 1);
        tick();
        chk("lit_mid_quiet", cmt_valid, 0);

        // allocate and commit together at count 1
        set_disp(38'h400, 5'b00001, 5'b0, '0);
        tick();
        clr_in();
        set_done(0, 0, 5'b00001, 1'b0);
        tick();
        clr_in();
        set_disp(38'h404, 5'b00001, 5'b0, '0);
        tick();
        clr_in();
        chk("lit_sim_id", disp_cmt_id, 2);
        chk("lit_sim_cmt", cmt_valid, 0);
        set_done(1, 1, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_sim_c1", cmt_id, 1);
        tick();

        // exception on head with three younger groups
        for (int i = 0; i < 4; i++) begin
            set_disp(38'(16'h500 + i), 5'b00001, 5'b0, '0);
            tick();
        end
        clr_in();
        set_done(0, 2, 5'b00001, 1'b1);
        set_done(1, 3, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_exc_cmt", cmt_exc, 1);
        chk("lit_exc_id", cmt_id, 2);
        tick();
        chk("lit_exc_flush", flush, 1);
        chk("lit_exc_nocmt", cmt_valid, 0);
        set_disp(38'h600, 5'b00001, 5'b0, '0);
        tick();
        clr_in();
        chk("lit_exc_fl_off", flush, 0);
        chk("lit_exc_tail", disp_cmt_id, 0);
        chk("lit_exc_ready", disp_ready, 1);

        // done to the id being allocated is ignored
        set_disp(38'h700, 5'b00001, 5'b0, '0);
        set_done(0, 0, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_same_cyc", cmt_valid, 0);
        tick();
        chk("lit_same_cyc2", cmt_valid, 0);
        set_done(0, 0, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_same_cmt", cmt_valid, 1);
        tick();

        // report to empty entry
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_err_clear", err, 0);
        set_done(0, 9, 5'b00001, 1'b0);
        tick();
        clr_in();
        chk("lit_err_set", err, EXP_ERR);
        tick();
        tick();
        chk("lit_err_hold", err, EXP_ERR);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_err_rst", err, 0);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
